exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the five-stage MIPS pipeline. It consumes the ID/EX latch outputs, computes the ALU/shift result, and registers the result into the EX/MEM latch it owns. It also detects load-use hazards against the instruction currently in ID, flags arithmetic overflow with a sticky exception bit, and counts stall cycles for lab measurement.

## Interface
Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- EWREG, EM2REG, EWMEM  in  1 each  control bits from ID/EX
- EALUC  in  3  ALU operation from ID/EX
- EALUIMM  in  1  1 = operand B is SA (sign-extended immediate)
- ESHIFT  in  1  1 = operand A is shamt SA[10:6], zero-extended
- EXE_SrcA, EXE_SrcB  in  32 each  register operands from ID/EX
- SA  in  32  sign-extended immediate from ID/EX
- EXE_REG_ADDR  in  5  destination register from ID/EX
- ID_RS, ID_RT  in  5 each  source registers of the instruction in ID
- ID_USE_RS, ID_USE_RT  in  1 each  ID instruction actually reads rs/rt
- EXC_CLR  in  1  synchronous clear of the sticky overflow flag
- MWREG, MM2REG, MWMEM  out  1 each  EX/MEM control bits
- MEM_ALU_OUT  out  32  registered ALU result
- MEM_STORE_DATA  out  32  registered EXE_SrcB, used for stores
- MEM_REG_ADDR  out  5  registered destination
- MEM_ZERO  out  1  registered (result == 0)
- STALL  out  1  combinational load-use stall request to PC/IF-ID/ID-EX control
- OV_EXC  out  1  sticky overflow flag
- STALL_CNT  out  STALL_CNT_W  saturating count of stall cycles

## Operation
- Operand A = ESHIFT ? {27'b0, SA[10:6]} : EXE_SrcA. Operand B = EALUIMM ? SA : EXE_SrcB.
- EALUC: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SLL (B << A[4:0]), 110 SUB (A−B), 111 SLT (signed, result 0/1).
- Overflow (ADD/SUB only): two's-complement signed overflow (operands same sign, result sign differs for ADD; operands differ, result sign differs from A for SUB). No other op raises it.
- On overflow: the instruction is killed in EX/MEM (MWREG=0, MWMEM=0, MM2REG=0); MEM_ALU_OUT, MEM_STORE_DATA, MEM_REG_ADDR still latch the computed values; OV_EXC set to 1.
- OV_EXC: sticky; cleared only by reset or EXC_CLR. Set and clear in the same cycle: set wins.
- Load-use: STALL = EWREG & EM2REG & (EXE_REG_ADDR != 0) & ((ID_USE_RS & ID_RS == EXE_REG_ADDR) | (ID_USE_RT & ID_RT == EXE_REG_ADDR)). Purely combinational from current inputs; this block does not hold its own latch on STALL (the load proceeds to MEM; the external ID/EX inserts the bubble).
- STALL_CNT increments by 1 each cycle STALL=1, saturates at all-ones, never wraps.

## Timing
- EX/MEM latch: all M* / MEM_* outputs update on the rising clk edge after inputs are valid; latency 1 cycle. ALU path is single-cycle combinational.
- Reset (rst=0, asynchronous, any time including mid-stall): MWREG=MM2REG=MWMEM=0, MEM_ALU_OUT=MEM_STORE_DATA=0, MEM_REG_ADDR=0, MEM_ZERO=0, OV_EXC=0, STALL_CNT=0. STALL remains combinational from inputs. Outputs hold reset values until the first rising edge after rst returns to 1.
- A bubble arriving from ID/EX (all control bits 0) propagates as a bubble; MEM_ZERO reflects its computed result regardless.
- Destination $0 never causes STALL; overflow on a write to $0 still sets OV_EXC.

## Test plan
- Reset: drive rst=0 mid-operation with EWREG=1 -> all registered outputs 0 immediately, STALL_CNT=0, OV_EXC=0.
- ALU: A=0x0000_0007, B=0x0000_0005, EALUC=110 -> MEM_ALU_OUT=0x0000_0002 one edge later; EALUC=111 with A=0xFFFF_FFFF,B=1 -> 1; ESHIFT=1, SA[10:6]=4, EALUC=101, B=0x1 -> 0x10.
- Immediate: EALUIMM=1, SA=0xFFFF_FFFC, A=0x10, ADD -> MEM_ALU_OUT=0x0C, MEM_ZERO=0; A=4 -> 0, MEM_ZERO=1.
- Overflow: A=0x7FFF_FFFF, B=1, ADD, EWREG=1 -> MWREG=0, OV_EXC=1, stays 1 over 5 cycles; EXC_CLR=1 -> 0 next edge; simultaneous overflow+EXC_CLR -> stays 1.
- Load-use: EWREG=EM2REG=1, EXE_REG_ADDR=8, ID_RT=8, ID_USE_RT=1 -> STALL=1 same cycle, STALL_CNT +1 per cycle; EXE_REG_ADDR=0 or ID_USE_RT=0 -> STALL=0.
- Saturation: STALL_CNT_W=2, hold stall 6 cycles -> STALL_CNT reaches 3 and stays 3.

Source files
------------

// File: rtl/exe_stage_if.sv
// Pipeline bundle between ID/EX and the EX/MEM latch of the execute stage.
// The master side drives the ID/EX fields; the slave side is the execute stage.
interface exe_stage_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   EWREG;
    logic                   EM2REG;
    logic                   EWMEM;
    logic [2:0]             EALUC;
    logic                   EALUIMM;
    logic                   ESHIFT;
    logic [31:0]            EXE_SrcA;
    logic [31:0]            EXE_SrcB;
    logic [31:0]            SA;
    logic [4:0]             EXE_REG_ADDR;
    logic [4:0]             ID_RS;
    logic [4:0]             ID_RT;
    logic                   ID_USE_RS;
    logic                   ID_USE_RT;
    logic                   EXC_CLR;
    logic                   MWREG;
    logic                   MM2REG;
    logic                   MWMEM;
    logic [31:0]            MEM_ALU_OUT;
    logic [31:0]            MEM_STORE_DATA;
    logic [4:0]             MEM_REG_ADDR;
    logic                   MEM_ZERO;
    logic                   STALL;
    logic                   OV_EXC;
    logic [STALL_CNT_W-1:0] STALL_CNT;

    modport master (
        output EWREG, EM2REG, EWMEM, EALUC, EALUIMM, ESHIFT, EXE_SrcA, EXE_SrcB, SA,
               EXE_REG_ADDR, ID_RS, ID_RT, ID_USE_RS, ID_USE_RT, EXC_CLR,
        input  MWREG, MM2REG, MWMEM, MEM_ALU_OUT, MEM_STORE_DATA, MEM_REG_ADDR,
               MEM_ZERO, STALL, OV_EXC, STALL_CNT
    );

    modport slave (
        input  EWREG, EM2REG, EWMEM, EALUC, EALUIMM, ESHIFT, EXE_SrcA, EXE_SrcB, SA,
               EXE_REG_ADDR, ID_RS, ID_RT, ID_USE_RS, ID_USE_RT, EXC_CLR,
        output MWREG, MM2REG, MWMEM, MEM_ALU_OUT, MEM_STORE_DATA, MEM_REG_ADDR,
               MEM_ZERO, STALL, OV_EXC, STALL_CNT
    );
endinterface

// File: rtl/exe_stage.sv
// MIPS execute stage: ALU/shift, EX/MEM latch, load-use stall detect,
// sticky overflow exception and saturating stall-cycle counter.
module exe_stage #(
    parameter int STALL_CNT_W = 16
) (
    input logic   clk,
    input logic   rst,
    exe_stage_if.slave bus
);
    logic [31:0]            op_a;
    logic [31:0]            op_b;
    logic [31:0]            sum;
    logic [31:0]            diff;
    logic [31:0]            result;
    logic                   ov;
    logic                   stall;

    logic                   mwreg_q;
    logic                   mm2reg_q;
    logic                   mwmem_q;
    logic [31:0]            alu_q;
    logic [31:0]            store_q;
    logic [4:0]             addr_q;
    logic                   zero_q;
    logic                   ov_exc_q;
    logic [STALL_CNT_W-1:0] cnt_q;

    assign op_a = bus.ESHIFT  ? {27'b0, bus.SA[10:6]} : bus.EXE_SrcA;
    assign op_b = bus.EALUIMM ? bus.SA : bus.EXE_SrcB;
    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    always_comb begin
        result = 32'h0;
        ov     = 1'b0;
        case (bus.EALUC)
            3'b000: result = op_a & op_b;
            3'b001: result = op_a | op_b;
            3'b010: begin
                result = sum;
                ov     = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
            end
            3'b011: result = op_a ^ op_b;
            3'b100: result = ~(op_a | op_b);
            3'b101: result = op_b << op_a[4:0];
            3'b110: begin
                result = diff;
                ov     = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
            end
            3'b111: result = {31'b0, $signed(op_a) < $signed(op_b)};
            default: result = 32'h0;
        endcase
    end

    // The load itself still advances to MEM; ID/EX outside inserts the bubble.
    assign stall = bus.EWREG && bus.EM2REG && (bus.EXE_REG_ADDR != 5'd0) &&
                   ((bus.ID_USE_RS && (bus.ID_RS == bus.EXE_REG_ADDR)) ||
                    (bus.ID_USE_RT && (bus.ID_RT == bus.EXE_REG_ADDR)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mwreg_q  <= 1'b0;
            mm2reg_q <= 1'b0;
            mwmem_q  <= 1'b0;
            alu_q    <= 32'h0;
            store_q  <= 32'h0;
            addr_q   <= 5'd0;
            zero_q   <= 1'b0;
            ov_exc_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // An overflowing instruction is killed but its datapath values still latch.
            mwreg_q  <= bus.EWREG  && !ov;
            mm2reg_q <= bus.EM2REG && !ov;
            mwmem_q  <= bus.EWMEM  && !ov;
            alu_q    <= result;
            store_q  <= bus.EXE_SrcB;
            addr_q   <= bus.EXE_REG_ADDR;
            zero_q   <= (result == 32'h0);
            if (ov)
                ov_exc_q <= 1'b1;
            else if (bus.EXC_CLR)
                ov_exc_q <= 1'b0;
            if (stall && (cnt_q != {STALL_CNT_W{1'b1}}))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.MWREG          = mwreg_q;
    assign bus.MM2REG         = mm2reg_q;
    assign bus.MWMEM          = mwmem_q;
    assign bus.MEM_ALU_OUT    = alu_q;
    assign bus.MEM_STORE_DATA = store_q;
    assign bus.MEM_REG_ADDR   = addr_q;
    assign bus.MEM_ZERO       = zero_q;
    assign bus.STALL          = stall;
    assign bus.OV_EXC         = ov_exc_q;
    assign bus.STALL_CNT      = cnt_q;
endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed vector table, hand-written
// overflow/stall/reset sequences, and random stimulus against a reference model.
module tb_exe_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    exe_stage_if #(.STALL_CNT_W(16)) bus ();
    exe_stage_if #(.STALL_CNT_W(2))  bus2 ();

    exe_stage #(.STALL_CNT_W(16)) u_dut  (.clk(clk), .rst(rst_n), .bus(bus));
    exe_stage #(.STALL_CNT_W(2))  u_dut2 (.clk(clk), .rst(rst_n), .bus(bus2));

    typedef struct {
        logic        esh;
        logic        eimm;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sa;
        logic [31:0] exp;
        logic        zero;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic esh, input logic eimm, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] sa);
        bus.ESHIFT = esh;  bus.EALUIMM = eimm; bus.EALUC = op;
        bus.EXE_SrcA = a;  bus.EXE_SrcB = b;  bus.SA = sa;
    endtask

    // Reference ALU from the arithmetic definitions: overflow is judged by
    // whether the exact signed 64-bit result fits in 32 bits.
    function automatic void ref_alu(input logic esh, input logic eimm, input logic [2:0] op,
                                    input logic [31:0] a_in, input logic [31:0] b_in,
                                    input logic [31:0] sa, output logic [31:0] r, output logic ov);
        logic [31:0] a;
        logic [31:0] b;
        longint      wide;
        a  = esh ? {27'b0, sa[10:6]} : a_in;
        b  = eimm ? sa : b_in;
        ov = 1'b0;
        r  = 32'h0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                wide = longint'($signed(a)) + longint'($signed(b));
                r = wide[31:0];
                ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            3'd3: r = a ^ b;
            3'd4: r = ~(a | b);
            3'd5: r = b << a[4:0];
            3'd6: begin
                wide = longint'($signed(a)) - longint'($signed(b));
                r = wide[31:0];
                ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        logic        ov;
        logic        exp_stall;
        int          ref_cnt;
        logic        ref_ov;
        logic        wr, m2r, wm, clr;
        logic [4:0]  dst;
        logic [31:0] b_cap;

        vecs[0]  = '{1'b0, 1'b0, 3'b110, 32'h7,        32'h5,        32'h0,        32'h2,        1'b0};
        vecs[1]  = '{1'b0, 1'b0, 3'b111, 32'hFFFF_FFFF, 32'h1,       32'h0,        32'h1,        1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b101, 32'h0000_DEAD, 32'h1,       32'h100,      32'h10,       1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'b010, 32'h10,       32'h55,       32'hFFFF_FFFC, 32'hC,       1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'b010, 32'h4,        32'h55,       32'hFFFF_FFFC, 32'h0,       1'b1};
        vecs[5]  = '{1'b0, 1'b0, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,     32'hF000_F000, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 3'b001, 32'h0F0F_0000, 32'h0000_00F0, 32'h0,     32'h0F0F_00F0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 3'b011, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0,     32'hF0F0_0F0F, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 3'b100, 32'h0,        32'h0,        32'h0,        32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 3'b111, 32'h5,        32'hFFFF_FFFF, 32'h0,       32'h0,        1'b1};
        vecs[10] = '{1'b0, 1'b0, 3'b110, 32'h3,        32'h3,        32'h0,        32'h0,        1'b1};

        bus.EWREG = 0; bus.EM2REG = 0; bus.EWMEM = 0; bus.EXE_REG_ADDR = 0;
        bus.ID_RS = 0; bus.ID_RT = 0; bus.ID_USE_RS = 0; bus.ID_USE_RT = 0; bus.EXC_CLR = 0;
        set_alu(0, 0, 3'b010, 32'h0, 32'h0, 32'h0);
        bus2.EWREG = 0; bus2.EM2REG = 0; bus2.EWMEM = 0; bus2.EALUC = 3'b000;
        bus2.EALUIMM = 0; bus2.ESHIFT = 0; bus2.EXE_SrcA = 0; bus2.EXE_SrcB = 0; bus2.SA = 0;
        bus2.EXE_REG_ADDR = 0; bus2.ID_RS = 0; bus2.ID_RT = 0; bus2.ID_USE_RS = 0;
        bus2.ID_USE_RT = 0; bus2.EXC_CLR = 0;

        // Reset state
        repeat (2) tick();
        chk("rst_mwreg", {31'b0, bus.MWREG}, 32'h0);
        chk("rst_alu", bus.MEM_ALU_OUT, 32'h0);
        chk("rst_zero", {31'b0, bus.MEM_ZERO}, 32'h0);
        chk("rst_cnt", {16'b0, bus.STALL_CNT}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Directed vector table
        bus.EWREG = 1; bus.EWMEM = 1; bus.EXE_REG_ADDR = 5'd5;
        for (int i = 0; i < 11; i++) begin
            set_alu(vecs[i].esh, vecs[i].eimm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sa);
            tick();
            chk($sformatf("vec%0d_out", i), bus.MEM_ALU_OUT, vecs[i].exp);
            chk($sformatf("vec%0d_zero", i), {31'b0, bus.MEM_ZERO}, {31'b0, vecs[i].zero});
            chk($sformatf("vec%0d_wreg", i), {31'b0, bus.MWREG}, 32'h1);
            chk($sformatf("vec%0d_store", i), bus.MEM_STORE_DATA, vecs[i].b);
            chk($sformatf("vec%0d_addr", i), {27'b0, bus.MEM_REG_ADDR}, 32'd5);
        end

        // Overflow kills the instruction and sets the sticky flag
        bus.EM2REG = 1;
        set_alu(0, 0, 3'b010, 32'h7FFF_FFFF, 32'h1, 32'h0);
        tick();
        chk("ov_mwreg", {31'b0, bus.MWREG}, 32'h0);
        chk("ov_mwmem", {31'b0, bus.MWMEM}, 32'h0);
        chk("ov_mm2reg", {31'b0, bus.MM2REG}, 32'h0);
        chk("ov_alu", bus.MEM_ALU_OUT, 32'h8000_0000);
        chk("ov_exc", {31'b0, bus.OV_EXC}, 32'h1);
        bus.EM2REG = 0;
        set_alu(0, 0, 3'b001, 32'h1, 32'h2, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("ov_sticky%0d", i), {31'b0, bus.OV_EXC}, 32'h1);
        end
        chk("ov_after_wreg", {31'b0, bus.MWREG}, 32'h1);
        bus.EXC_CLR = 1;
        tick();
        chk("ov_clr", {31'b0, bus.OV_EXC}, 32'h0);
        set_alu(0, 0, 3'b110, 32'h8000_0000, 32'h1, 32'h0);
        tick();
        chk("ov_set_wins", {31'b0, bus.OV_EXC}, 32'h1);
        chk("ov_sub_kill", {31'b0, bus.MWREG}, 32'h0);
        set_alu(0, 0, 3'b001, 32'h0, 32'h0, 32'h0);
        tick();
        chk("ov_clr2", {31'b0, bus.OV_EXC}, 32'h0);
        bus.EXC_CLR = 0;
        bus.EXE_REG_ADDR = 5'd0;
        set_alu(0, 0, 3'b010, 32'h8000_0000, 32'h8000_0000, 32'h0);
        tick();
        chk("ov_r0_sets", {31'b0, bus.OV_EXC}, 32'h1);
        bus.EXC_CLR = 1;
        set_alu(0, 0, 3'b000, 32'h0, 32'h0, 32'h0);
        tick();
        bus.EXC_CLR = 0;

        // Load-use stall detect and counting
        bus.EWREG = 1; bus.EM2REG = 1; bus.EXE_REG_ADDR = 5'd8;
        bus.ID_RT = 5'd8; bus.ID_USE_RT = 1; bus.ID_RS = 5'd3; bus.ID_USE_RS = 1;
        #1;
        chk("stall_rt", {31'b0, bus.STALL}, 32'h1);
        ref_cnt = int'(bus.STALL_CNT);
        chk("stall_cnt_base", {16'b0, bus.STALL_CNT}, 32'h0);
        repeat (3) tick();
        chk("stall_cnt3", {16'b0, bus.STALL_CNT}, 32'd3);
        bus.EXE_REG_ADDR = 5'd0; bus.ID_RT = 5'd0; #1;
        chk("stall_r0", {31'b0, bus.STALL}, 32'h0);
        bus.EXE_REG_ADDR = 5'd8; bus.ID_RT = 5'd8; bus.ID_USE_RT = 0; #1;
        chk("stall_nouse", {31'b0, bus.STALL}, 32'h0);
        bus.ID_RS = 5'd8; #1;
        chk("stall_rs", {31'b0, bus.STALL}, 32'h1);
        bus.EM2REG = 0; #1;
        chk("stall_noload", {31'b0, bus.STALL}, 32'h0);
        tick();
        chk("stall_cnt_hold", {16'b0, bus.STALL_CNT}, 32'd3);

        // Saturation on the 2-bit counter instance
        bus2.EWREG = 1; bus2.EM2REG = 1; bus2.EXE_REG_ADDR = 5'd9;
        bus2.ID_RS = 5'd9; bus2.ID_USE_RS = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("sat%0d", i), {30'b0, bus2.STALL_CNT}, (i < 3) ? i : 3);
        end

        // Asynchronous reset mid-stall
        bus.EWREG = 1; bus.EM2REG = 1; bus.EWMEM = 1; bus.ID_USE_RT = 1;
        set_alu(0, 0, 3'b001, 32'h1234, 32'h5678, 32'h0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mwreg", {31'b0, bus.MWREG}, 32'h0);
        chk("arst_alu", bus.MEM_ALU_OUT, 32'h0);
        chk("arst_store", bus.MEM_STORE_DATA, 32'h0);
        chk("arst_cnt", {16'b0, bus.STALL_CNT}, 32'h0);
        chk("arst_cnt2", {30'b0, bus2.STALL_CNT}, 32'h0);
        chk("arst_stall_comb", {31'b0, bus.STALL}, 32'h1);
        tick();
        chk("arst_hold", bus.MEM_ALU_OUT, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("arst_release_hold", {31'b0, bus.MWREG}, 32'h0);

        // Random stimulus against the reference model
        ref_cnt = 0;
        ref_ov  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            wr  = $urandom_range(0, 1);
            m2r = $urandom_range(0, 1);
            wm  = $urandom_range(0, 1);
            clr = ($urandom_range(0, 7) == 0);
            dst = 5'($urandom_range(0, 3));
            bus.EWREG = wr; bus.EM2REG = m2r; bus.EWMEM = wm; bus.EXC_CLR = clr;
            bus.EXE_REG_ADDR = dst;
            bus.ID_RS = 5'($urandom_range(0, 3)); bus.ID_RT = 5'($urandom_range(0, 3));
            bus.ID_USE_RS = 1'($urandom_range(0, 1)); bus.ID_USE_RT = 1'($urandom_range(0, 1));
            b_cap = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            set_alu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom, b_cap, $urandom);
            #1;
            ref_alu(bus.ESHIFT, bus.EALUIMM, bus.EALUC, bus.EXE_SrcA, bus.EXE_SrcB, bus.SA, r, ov);
            exp_stall = wr && m2r && (dst != 0) &&
                        ((bus.ID_USE_RS && bus.ID_RS == dst) || (bus.ID_USE_RT && bus.ID_RT == dst));
            chk("rnd_stall", {31'b0, bus.STALL}, {31'b0, exp_stall});
            tick();
            if (exp_stall) ref_cnt++;
            if (ov) ref_ov = 1'b1;
            else if (clr) ref_ov = 1'b0;
            chk("rnd_alu", bus.MEM_ALU_OUT, r);
            chk("rnd_zero", {31'b0, bus.MEM_ZERO}, {31'b0, r == 32'h0});
            chk("rnd_ctrl", {29'b0, bus.MWREG, bus.MM2REG, bus.MWMEM},
                {29'b0, wr && !ov, m2r && !ov, wm && !ov});
            chk("rnd_store", bus.MEM_STORE_DATA, b_cap);
            chk("rnd_addr", {27'b0, bus.MEM_REG_ADDR}, {27'b0, dst});
            chk("rnd_ov", {31'b0, bus.OV_EXC}, {31'b0, ref_ov});
            chk("rnd_cnt", {16'b0, bus.STALL_CNT}, 32'(ref_cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
